// File: rtl/watch_uart_pkg.sv
// Shared constants for the watch UART transmit path: ASCII codes,
// formatter state encoding, frame lengths and time-field limits.
package watch_uart_pkg;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_DASH = 8'h2D;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SEND     = 3'd1;
    localparam logic [2:0] ST_WAIT_ACK = 3'd2;
    localparam logic [2:0] ST_WAIT_TX  = 3'd3;
    localparam logic [2:0] ST_DONE     = 3'd4;

    typedef enum logic [2:0] {
        IDLE     = ST_IDLE,
        SEND     = ST_SEND,
        WAIT_ACK = ST_WAIT_ACK,
        WAIT_TX  = ST_WAIT_TX,
        DONE     = ST_DONE
    } fmt_state_t;

    localparam int FRAME_LEN_SHORT = 11;
    localparam int FRAME_LEN_CRLF  = 13;

    localparam logic [6:0] HOUR_MAX = 7'd23;
    localparam logic [6:0] MIN_MAX  = 7'd59;
    localparam logic [6:0] SEC_MAX  = 7'd59;
    localparam logic [6:0] CS_MAX   = 7'd99;

    function automatic logic [7:0] ascii_digit(input logic [6:0] d);
        return ASCII_ZERO + {1'b0, d};
    endfunction

endpackage

// File: rtl/watch_bin2ascii2.sv
// Two-digit decimal to ASCII converter; a value above max_val
// is rendered as "--" so a corrupt field is visible on the wire.
module watch_bin2ascii2
    import watch_uart_pkg::*;
(
    input  logic [6:0] value,
    input  logic [6:0] max_val,
    output logic [7:0] tens,
    output logic [7:0] ones
);

    logic [6:0] quo;
    logic [6:0] rem;

    always_comb begin
        quo = value / 7'd10;
        rem = value % 7'd10;
        if (value > max_val) begin
            tens = ASCII_DASH;
            ones = ASCII_DASH;
        end else begin
            tens = ascii_digit(quo);
            ones = ascii_digit(rem);
        end
    end

endmodule

// File: rtl/watch_time_uart_tx_fmt.sv
// Formats a time snapshot as "HH:MM:SS.CC[\r\n]" into the UART TX.
// Optional WATCH_TX_AUTO_REPORT_EN: send a frame on every i_sec change.
module watch_time_uart_tx_fmt
    import watch_uart_pkg::*;
#(
    parameter logic [7:0] SEP_HMS   = 8'h3A,
    parameter logic [7:0] SEP_CS    = 8'h2E,
    parameter bit         SEND_CRLF = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_send,
    input  logic [6:0] i_msec,
    input  logic [5:0] i_sec,
    input  logic [5:0] i_min,
    input  logic [4:0] i_hour,
    input  logic       i_tx_busy,
    output logic       o_tx_start,
    output logic [7:0] o_tx_data,
    output logic       o_busy,
    output logic       o_done
);

    localparam int FRAME_LEN = SEND_CRLF ? FRAME_LEN_CRLF
                                         : FRAME_LEN_SHORT;
    localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);

    fmt_state_t state_q, state_d;
    logic [3:0] idx_q, idx_d;
    logic       pending_q, pending_d;
    logic       snap_load;
    logic       load_byte;
    logic       req;

    logic [4:0] snap_hour;
    logic [5:0] snap_min;
    logic [5:0] snap_sec;
    logic [6:0] snap_cs;

    logic       tx_start_q;
    logic [7:0] tx_data_q;
    logic [7:0] cur_byte;

    logic [7:0] h_t, h_o, m_t, m_o, s_t, s_o, c_t, c_o;

`ifdef WATCH_TX_AUTO_REPORT_EN
    logic [5:0] sec_hist_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sec_hist_q <= '0;
        else     sec_hist_q <= i_sec;
    end

    assign req = i_send | (i_sec != sec_hist_q);
`else
    assign req = i_send;
`endif

    watch_bin2ascii2 u_hour (
        .value   ({2'b00, snap_hour}),
        .max_val (HOUR_MAX),
        .tens    (h_t),
        .ones    (h_o)
    );

    watch_bin2ascii2 u_min (
        .value   ({1'b0, snap_min}),
        .max_val (MIN_MAX),
        .tens    (m_t),
        .ones    (m_o)
    );

    watch_bin2ascii2 u_sec (
        .value   ({1'b0, snap_sec}),
        .max_val (SEC_MAX),
        .tens    (s_t),
        .ones    (s_o)
    );

    watch_bin2ascii2 u_cs (
        .value   (snap_cs),
        .max_val (CS_MAX),
        .tens    (c_t),
        .ones    (c_o)
    );

    always_comb begin
        cur_byte = '0;
        case (idx_q)
            4'd0:    cur_byte = h_t;
            4'd1:    cur_byte = h_o;
            4'd2:    cur_byte = SEP_HMS;
            4'd3:    cur_byte = m_t;
            4'd4:    cur_byte = m_o;
            4'd5:    cur_byte = SEP_HMS;
            4'd6:    cur_byte = s_t;
            4'd7:    cur_byte = s_o;
            4'd8:    cur_byte = SEP_CS;
            4'd9:    cur_byte = c_t;
            4'd10:   cur_byte = c_o;
            4'd11:   cur_byte = ASCII_CR;
            4'd12:   cur_byte = ASCII_LF;
            default: cur_byte = '0;
        endcase
    end

    // Requests arriving mid-frame collapse into one pending slot.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pending_d = pending_q;
        snap_load = 1'b0;
        load_byte = 1'b0;
        case (state_q)
            IDLE: begin
                if (req || pending_q) begin
                    snap_load = 1'b1;
                    idx_d     = '0;
                    pending_d = 1'b0;
                    state_d   = SEND;
                end
            end
            SEND: begin
                pending_d = pending_q | req;
                if (!i_tx_busy) begin
                    load_byte = 1'b1;
                    state_d   = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                pending_d = pending_q | req;
                if (i_tx_busy) state_d = WAIT_TX;
            end
            WAIT_TX: begin
                pending_d = pending_q | req;
                if (!i_tx_busy) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = SEND;
                    end
                end
            end
            DONE: begin
                if (pending_q) begin
                    pending_d = 1'b0;
                    snap_load = 1'b1;
                    idx_d     = '0;
                    state_d   = SEND;
                end else begin
                    pending_d = req;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            pending_q  <= 1'b0;
            snap_hour  <= '0;
            snap_min   <= '0;
            snap_sec   <= '0;
            snap_cs    <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            pending_q  <= pending_d;
            tx_start_q <= load_byte;
            if (load_byte) tx_data_q <= cur_byte;
            if (snap_load) begin
                snap_hour <= i_hour;
                snap_min  <= i_min;
                snap_sec  <= i_sec;
                snap_cs   <= i_msec;
            end
        end
    end

    assign o_tx_start = tx_start_q;
    assign o_tx_data  = tx_data_q;
    assign o_busy     = (state_q != IDLE);
    assign o_done     = (state_q == DONE);

endmodule

// File: doc/watch_time_uart_tx_fmt.md
Name: watch_time_uart_tx_fmt

Overview:
- Formats the watch time (hour/min/sec/centisecond) as ASCII text and drives it byte-by-byte into the existing UART transmitter.
- Sits between the watch datapath time outputs and the uart_tx start/busy interface, on the transmit side of the watch_uart design.
- Snapshots the time at request so every frame is internally consistent.
- Frame format: "HH:MM:SS.CC\r\n".

Parameters:
- SEP_HMS, 8'h3A, separator byte between HH/MM and MM/SS (':').
- SEP_CS, 8'h2E, separator byte between SS and CC ('.').
- SEND_CRLF, 1, 1 = append CR (8'h0D) and LF (8'h0A), giving a 13-byte frame; 0 = 11-byte frame.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- i_send  in  1  single-cycle request to transmit one frame
- i_msec  in  7  centiseconds, 0..99
- i_sec  in  6  seconds, 0..59
- i_min  in  6  minutes, 0..59
- i_hour  in  5  hours, 0..23
- i_tx_busy  in  1  UART TX busy (high while a byte is shifting out)
- o_tx_start  out  1  single-cycle start strobe to UART TX
- o_tx_data  out  8  byte to send; stable from the start cycle until busy falls
- o_busy  out  1  high while a frame is in progress
- o_done  out  1  single-cycle pulse when the last byte completes

Behaviour:
- Reset values:
  - State IDLE.
  - o_tx_start=0, o_tx_data=8'h00, o_busy=0, o_done=0.
  - Byte index=0, pending=0, snapshot=0.
- States:
  - IDLE: on i_send=1, register the snapshot of all four time inputs and byte index=0, then go to SEND.
  - SEND: if i_tx_busy=0, assert o_tx_start for 1 cycle with o_tx_data=byte[index], then go to WAIT_ACK. If i_tx_busy=1, hold in SEND without a strobe.
  - WAIT_ACK: wait for i_tx_busy=1, then go to WAIT_TX.
  - WAIT_TX: wait for i_tx_busy=0.
    - If index = last, go to DONE.
    - Otherwise index+1 and go to SEND.
  - DONE: o_done=1 for exactly 1 cycle.
    - If pending=1, clear pending, take a new snapshot, and go to SEND with index=0.
    - Otherwise go to IDLE.
- Latency: i_send sampled at edge N causes o_tx_start high in the cycle after edge N+1 (first SEND cycle), when the TX is idle.
- Byte order: H tens, H ones, SEP_HMS, M tens, M ones, SEP_HMS, S tens, S ones, SEP_CS, C tens, C ones, [CR, LF].
- Digit conversion: tens = v/10, ones = v%10, each digit sent as 8'h30+digit. Arithmetic is on the snapshot only; live inputs may change mid-frame without effect.
- Out-of-range field (hour>23, min>59, sec>59, msec>99): both digits of that field are sent as '-' (8'h2D). Other fields are unaffected.
- o_busy=1 in every state except IDLE, including DONE.
- Request while busy: i_send when state≠IDLE sets a 1-deep pending flag. Further requests while pending=1 are dropped. i_send in the DONE cycle also sets pending.
- o_tx_data holds its last value when idle; it is don't-care outside the start-to-busy-fall window.
- Reset mid-frame: immediate return to IDLE with all reset values. The partial frame is abandoned and pending is cleared.

Optional Feature:
- Macro: WATCH_TX_AUTO_REPORT_EN.
- Defined: an internal register tracks i_sec. A change of i_sec while in IDLE acts as an internal i_send, giving one frame per second. A change while not in IDLE sets pending. i_send still works.
- Undefined: frames are sent only on i_send; no i_sec history register is built.

Decomposition:
- Shared package watch_uart_pkg:
  - ASCII constants (0x30 digit base, 0x2D dash, 0x0D CR, 0x0A LF).
  - State encoding localparams: IDLE, SEND, WAIT_ACK, WAIT_TX, DONE.
  - Frame lengths 11/13.
  - Field maxima 23/59/99.
- One sub-module, watch_bin2ascii2: combinational 7-bit value + max limit → two ASCII bytes, with the '-' substitution. Instantiated four times on the snapshot registers.

Test Plan:
- Basic frame: hour=12, min=34, sec=56, msec=7; i_send pulse; TX model raises busy 1 cycle after start and holds it 10 cycles.
  → 13 strobes, bytes 31 32 3A 33 34 3A 35 36 2E 30 37 0D 0A, one o_done pulse, then o_busy=0.
- Snapshot consistency: inputs change to 13:00:00.00 after the 2nd byte → frame still "12:34:56.07"; the second request sends "13:00:00.00".
- Out of range: msec=120, hour=23 → bytes 10-11 = 2D 2D, bytes 1-2 = 32 33.
- Pending: i_send twice during one frame → exactly two frames back-to-back, the second starting in the cycle after DONE. A third i_send during the first frame is dropped.
- Busy hold: i_tx_busy=1 at request → no o_tx_start until busy falls, then the first byte 8'h31.
- Reset mid-frame: assert rst during byte 5 → o_tx_start=0, o_busy=0, o_tx_data=00. A subsequent i_send restarts from byte 0.
